cpu_seq: RTL and testbench

Parametrised program sequencer for the single-cycle CPU control path. It replaces the fixed PC/jump/link-register trio with one block that owns:
- the program counter;
- a base register;
- a STACK_DEPTH-deep return-address stack, for nested calls;
- flag-conditional and PC-relative branching, stall and halt.

It sits between the instruction decoder (which supplies `op`, `cond` and `target` each cycle) and the instruction ROM (which is addressed by `pc_out`).

---
 rtl/cpu_seq.sv | 149 ++++++++++++++
 tb/tb_cpu_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq.sv
// Program sequencer: program counter, base register, return-address stack,
// conditional/relative branching, stall and halt for the single-cycle CPU.
module cpu_seq #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [1:0]       cond,
  input  logic [WIDTH-1:0] target,
  input  logic             base_ld,
  input  logic [WIDTH-1:0] base_data,
  input  logic             z_flag,
  input  logic             c_flag,
  input  logic             n_flag,
  output logic [WIDTH-1:0] pc_out,
  output logic [SP_W-1:0]  sp_out,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             halted,
  output logic             fault_ovf,
  output logic             fault_unf
);

  localparam int IDX_W = SP_W - 1;

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_JMP  = 3'b001,
    OP_JMPB = 3'b010,
    OP_JC   = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_HALT = 3'b110,
    OP_JREL = 3'b111
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             halted_q, halted_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pop_data;
  logic [SP_W-1:0]  sp_dec;
  logic             cond_true;
  logic             full;
  logic             empty;
  logic             push_en;
  op_e              op_w;

  assign op_w  = op_e'(op);
  assign full  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty = (sp_q == '0);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d      = pc_q;
    base_d    = base_q;
    sp_d      = sp_q;
    halted_d  = halted_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push_en   = 1'b0;
    cond_true = 1'b0;
    pc_inc    = pc_q + WIDTH'(1);
    sp_dec    = sp_q - SP_W'(1);
    pop_data  = stack_q[sp_dec[IDX_W-1:0]];

    case (cond)
      2'b00:   cond_true = z_flag;
      2'b01:   cond_true = !z_flag;
      2'b10:   cond_true = c_flag;
      default: cond_true = n_flag;
    endcase

    if (en && !halted_q) begin
      if (base_ld) base_d = base_data;
      case (op_w)
        OP_NEXT: pc_d = pc_inc;
        OP_JMP:  pc_d = target;
        OP_JMPB: pc_d = base_q + target;
        OP_JC:   pc_d = cond_true ? target : pc_inc;
        OP_CALL: begin
          if (full) begin
            pc_d  = pc_inc;
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            pc_d    = target;
          end
        end
        OP_RET: begin
          if (empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            sp_d = sp_dec;
            pc_d = pop_data;
          end
        end
        OP_HALT: halted_d = 1'b1;
        // A WIDTH-bit add modulo 2^WIDTH equals adding the sign-extended offset.
        OP_JREL: pc_d = pc_q + target;
        default: pc_d = pc_inc;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q     <= '0;
      base_q   <= '0;
      sp_q     <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      base_q   <= base_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // NOTE: the stack array has no reset; entries are only read below sp, which reset clears.
  always_ff @(posedge clk) begin
    if (rst && push_en) stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
  end

  assign pc_out      = pc_q;
  assign sp_out      = sp_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign halted      = halted_q;
  assign fault_ovf   = ovf_q;
  assign fault_unf   = unf_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Scoreboard bench for cpu_seq: a behavioural model predicts each edge's
// state when stimulus is driven; a monitor pops and compares after the edge.
module tb_cpu_seq;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b1;
  logic [2:0]   op = 3'b000;
  logic [1:0]   cond = 2'b00;
  logic [W-1:0] target = '0;
  logic         base_ld = 1'b0;
  logic [W-1:0] base_data = '0;
  logic         z_flag = 1'b0, c_flag = 1'b0, n_flag = 1'b0;
  logic [W-1:0] pc_out;
  logic [2:0]   sp_out;
  logic         stack_empty, stack_full, halted, fault_ovf, fault_unf;

  cpu_seq #(.WIDTH(W), .STACK_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .cond(cond), .target(target),
    .base_ld(base_ld), .base_data(base_data),
    .z_flag(z_flag), .c_flag(c_flag), .n_flag(n_flag),
    .pc_out(pc_out), .sp_out(sp_out), .stack_empty(stack_empty),
    .stack_full(stack_full), .halted(halted),
    .fault_ovf(fault_ovf), .fault_unf(fault_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pc;
    int           sp;
    logic         halt;
    logic         ovf;
    logic         unf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [W-1:0] m_pc = '0, m_base = '0;
  logic [W-1:0] m_stack [D];
  int           m_sp = 0;
  logic         m_halt = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic step(input logic [2:0] op_v, input logic [W-1:0] tgt,
                      input logic [1:0] cond_v = 2'b00, input logic e = 1'b1,
                      input logic zf = 1'b0, input logic cf = 1'b0, input logic nf = 1'b0,
                      input logic bld = 1'b0, input logic [W-1:0] bdat = '0,
                      input logic r = 1'b1);
    logic [W-1:0] old_base;
    logic         taken;
    exp_t         x;
    @(negedge clk);
    rst = r; en = e; op = op_v; cond = cond_v; target = tgt;
    z_flag = zf; c_flag = cf; n_flag = nf; base_ld = bld; base_data = bdat;
    if (!r) begin
      m_pc = '0; m_base = '0; m_sp = 0; m_halt = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (e && !m_halt) begin
      old_base = m_base;
      if (bld) m_base = bdat;
      case (op_v)
        3'd0: m_pc = m_pc + 8'd1;
        3'd1: m_pc = tgt;
        3'd2: m_pc = old_base + tgt;
        3'd3: begin
          case (cond_v)
            2'b00: taken = zf;
            2'b01: taken = !zf;
            2'b10: taken = cf;
            default: taken = nf;
          endcase
          m_pc = taken ? tgt : m_pc + 8'd1;
        end
        3'd4: begin
          if (m_sp == D) begin m_ovf = 1'b1; m_pc = m_pc + 8'd1; end
          else begin m_stack[m_sp] = m_pc + 8'd1; m_sp++; m_pc = tgt; end
        end
        3'd5: begin
          if (m_sp == 0) begin m_unf = 1'b1; m_pc = m_pc + 8'd1; end
          else begin m_sp--; m_pc = m_stack[m_sp]; end
        end
        3'd6: m_halt = 1'b1;
        default: m_pc = W'(int'(m_pc) + int'($signed(tgt)));
      endcase
    end
    x.pc = m_pc; x.sp = m_sp; x.halt = m_halt; x.ovf = m_ovf; x.unf = m_unf;
    sb_q.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("pc", 32'(pc_out), 32'(x.pc));
      check("sp", 32'(sp_out), 32'(x.sp));
      check("empty", 32'(stack_empty), 32'(x.sp == 0));
      check("full", 32'(stack_full), 32'(x.sp == D));
      check("halted", 32'(halted), 32'(x.halt));
      check("ovf", 32'(fault_ovf), 32'(x.ovf));
      check("unf", 32'(fault_unf), 32'(x.unf));
    end
  end

  // Direct check of the DUT just after the edge that consumed the last step.
  task automatic expect_pc(input string tag, input logic [W-1:0] v);
    @(posedge clk); #2;
    check(tag, 32'(pc_out), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset and sequential fetch
    step(3'd0, 8'h00, .r(1'b0));
    step(3'd0, 8'h00, .r(1'b0));
    expect_pc("reset_pc", 8'h00);
    repeat (3) step(3'd0, 8'h00);
    expect_pc("next3", 8'h03);
    step(3'd1, 8'hFF);
    step(3'd0, 8'h00);
    expect_pc("wrap", 8'h00);

    // Jumps
    step(3'd1, 8'h40);
    expect_pc("jmp", 8'h40);
    step(3'd2, 8'h05, .bld(1'b1), .bdat(8'h20));
    expect_pc("jmpb_old_base", 8'h05);
    step(3'd2, 8'h05);
    expect_pc("jmpb_new_base", 8'h25);
    step(3'd7, 8'hFE);
    expect_pc("jrel_neg", 8'h23);

    // Conditional: not-taken then taken for each condition
    step(3'd3, 8'h10, .cond_v(2'b00), .zf(1'b0));
    expect_pc("jc_z_nt", 8'h24);
    step(3'd3, 8'h10, .cond_v(2'b00), .zf(1'b1));
    expect_pc("jc_z_t", 8'h10);
    step(3'd3, 8'h10, .cond_v(2'b01), .zf(1'b1));
    step(3'd3, 8'h10, .cond_v(2'b01), .zf(1'b0));
    step(3'd3, 8'h10, .cond_v(2'b10), .cf(1'b0));
    step(3'd3, 8'h10, .cond_v(2'b10), .cf(1'b1));
    step(3'd3, 8'h10, .cond_v(2'b11), .nf(1'b0));
    step(3'd3, 8'h10, .cond_v(2'b11), .nf(1'b1));
    expect_pc("jc_n_t", 8'h10);

    // Call stack fill, overflow, unwind, underflow
    step(3'd4, 8'h30);
    step(3'd4, 8'h50);
    step(3'd4, 8'h70);
    step(3'd4, 8'h90);
    expect_pc("call4", 8'h90);
    step(3'd4, 8'hA0);
    expect_pc("call_ovf", 8'h91);
    step(3'd5, 8'h00);
    expect_pc("ret1", 8'h71);
    step(3'd5, 8'h00);
    step(3'd5, 8'h00);
    step(3'd5, 8'h00);
    expect_pc("ret4", 8'h11);
    step(3'd5, 8'h00);
    expect_pc("ret_unf", 8'h12);

    // Stall during a CALL, with base_ld ignored
    repeat (3) step(3'd4, 8'h60, .e(1'b0), .bld(1'b1), .bdat(8'h77));
    expect_pc("stall", 8'h12);

    // Halt under random stimulus
    step(3'd6, 8'h00);
    for (int i = 0; i < 10; i++)
      step(3'($urandom_range(0, 7)), 8'($urandom), .e(1'($urandom)),
           .bld(1'($urandom)), .bdat(8'($urandom)));
    expect_pc("halt_hold", 8'h12);

    // Reset out of halt, then base (still 0 after ignored stalled load) and CALL/RET back-to-back
    step(3'd4, 8'h55, .r(1'b0));
    expect_pc("reset_halt", 8'h00);
    step(3'd0, 8'h00);
    step(3'd2, 8'h03, .e(1'b0), .bld(1'b1), .bdat(8'h77));
    step(3'd2, 8'h03);
    expect_pc("jmpb_base0", 8'h03);
    step(3'd4, 8'h80);
    step(3'd5, 8'h00);
    expect_pc("call_ret", 8'h04);

    // Reset asserted mid call sequence with en low
    step(3'd4, 8'hC0);
    step(3'd4, 8'hD0, .e(1'b0), .r(1'b0));
    step(3'd0, 8'h00);
    expect_pc("reset_midcall", 8'h01);

    repeat (2) @(posedge clk);
    #2;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
